// File: rtl/axi_lite_master_arb.sv
// ---------------------------------------------------------------------------
// axi_lite_master_arb
// Shares one AXI-Lite master port between NUM_REQ single-beat requesters.
// Requests are granted round-robin; exactly one AXI transaction is in flight
// at a time, and the result is returned with a one-cycle req_ack pulse.
//
// Ports
//   ACLK, ARESET              clock, asynchronous active-high reset
//   req/req_we                per-requester command strobe and write select
//   req_addr/req_wdata        packed per-requester address / write data
//   req_ack                   one-cycle completion pulse to the granted requester
//   rsp_rdata/rsp_resp        read data / response, valid with req_ack, held after
//   AW*/W*/B*/AR*/R*          AXI-Lite master channels
// ---------------------------------------------------------------------------
module axi_lite_master_arb #(
    parameter int unsigned NUM_REQ   = 2,
    parameter logic [3:0]  AXI_CACHE = 4'b0000,
    parameter logic [2:0]  AXI_PROT  = 3'b000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,

    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_we,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [31:0]             rsp_rdata,
    output logic [1:0]              rsp_resp,

    output logic [31:0]             AWADDR,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [3:0]              AWCACHE,
    output logic [2:0]              AWPROT,

    output logic [31:0]             WDATA,
    output logic                    WVALID,
    input  logic                    WREADY,

    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,

    output logic [31:0]             ARADDR,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic [3:0]              ARCACHE,
    output logic [2:0]              ARPROT,

    input  logic [31:0]             RDATA,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WR_B  = 3'd2;
    localparam logic [2:0] S_RD_AR = 3'd3;
    localparam logic [2:0] S_RD_R  = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;

    // Sideband attributes are fixed for every transaction, reset included.
    assign AWCACHE = AXI_CACHE;
    assign ARCACHE = AXI_CACHE;
    assign AWPROT  = AXI_PROT;
    assign ARPROT  = AXI_PROT;

    // Unpacked views of the packed per-requester buses.
    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[ADDR_W*g +: ADDR_W];
        assign wdata_arr[g] = req_wdata[DATA_W*g +: DATA_W];
    end

    // State and captured transaction context.
    logic [2:0]        state,     state_nxt;
    logic [IDX_W-1:0]  idx_q,     idx_nxt;
    logic [IDX_W-1:0]  rr_ptr,    rr_nxt;
    logic              aw_done,   aw_done_nxt;
    logic              w_done,    w_done_nxt;

    // Next values of the registered outputs.
    logic [ADDR_W-1:0]  awaddr_nxt;
    logic               awvalid_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               wvalid_nxt;
    logic               bready_nxt;
    logic [ADDR_W-1:0]  araddr_nxt;
    logic               arvalid_nxt;
    logic               rready_nxt;
    logic [NUM_REQ-1:0] req_ack_nxt;
    logic [DATA_W-1:0]  rdata_nxt;
    logic [1:0]         resp_nxt;

    // Round-robin pick: first requester above rr_ptr, else first at/below it.
    logic              hi_found, lo_found, gnt_found;
    logic [IDX_W-1:0]  hi_idx, lo_idx, gnt_idx;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !hi_found && (IDX_W'(i) > rr_ptr)) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(i);
            end
            if (req[i] && !lo_found && (IDX_W'(i) <= rr_ptr)) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
        gnt_found = hi_found | lo_found;
        gnt_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Handshake completion this cycle, or already done earlier in WR.
    logic aw_hs, w_hs, aw_fin, w_fin;

    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx_q;
        rr_nxt      = rr_ptr;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        awaddr_nxt  = AWADDR;
        awvalid_nxt = AWVALID;
        wdata_nxt   = WDATA;
        wvalid_nxt  = WVALID;
        bready_nxt  = BREADY;
        araddr_nxt  = ARADDR;
        arvalid_nxt = ARVALID;
        rready_nxt  = RREADY;
        req_ack_nxt = '0;
        rdata_nxt   = rsp_rdata;
        resp_nxt    = rsp_resp;

        case (state)
            S_IDLE: begin
                if (gnt_found) begin
                    idx_nxt = gnt_idx;
                    rr_nxt  = gnt_idx;
                    if (req_we[gnt_idx]) begin
                        state_nxt   = S_WR;
                        awaddr_nxt  = addr_arr[gnt_idx];
                        wdata_nxt   = wdata_arr[gnt_idx];
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        aw_done_nxt = 1'b0;
                        w_done_nxt  = 1'b0;
                    end else begin
                        state_nxt   = S_RD_AR;
                        araddr_nxt  = addr_arr[gnt_idx];
                        arvalid_nxt = 1'b1;
                    end
                end
            end

            // AW and W complete independently; each VALID drops after its own handshake.
            S_WR: begin
                if (aw_hs) begin
                    awvalid_nxt = 1'b0;
                    aw_done_nxt = 1'b1;
                end
                if (w_hs) begin
                    wvalid_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_nxt  = S_WR_B;
                    bready_nxt = 1'b1;
                end
            end

            S_WR_B: begin
                if (BVALID) begin
                    state_nxt   = S_ACK;
                    bready_nxt  = 1'b0;
                    resp_nxt    = BRESP;
                    req_ack_nxt = NUM_REQ'(1) << idx_q;
                end
            end

            S_RD_AR: begin
                if (ARREADY) begin
                    state_nxt   = S_RD_R;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                end
            end

            S_RD_R: begin
                if (RVALID) begin
                    state_nxt   = S_ACK;
                    rready_nxt  = 1'b0;
                    rdata_nxt   = RDATA;
                    resp_nxt    = 2'b00;
                    req_ack_nxt = NUM_REQ'(1) << idx_q;
                end
            end

            // req_ack is high during this state; requester drops req here.
            S_ACK: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= S_IDLE;
            idx_q     <= '0;
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            req_ack   <= '0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            state     <= state_nxt;
            idx_q     <= idx_nxt;
            rr_ptr    <= rr_nxt;
            aw_done   <= aw_done_nxt;
            w_done    <= w_done_nxt;
            AWADDR    <= awaddr_nxt;
            AWVALID   <= awvalid_nxt;
            WDATA     <= wdata_nxt;
            WVALID    <= wvalid_nxt;
            BREADY    <= bready_nxt;
            ARADDR    <= araddr_nxt;
            ARVALID   <= arvalid_nxt;
            RREADY    <= rready_nxt;
            req_ack   <= req_ack_nxt;
            rsp_rdata <= rdata_nxt;
            rsp_resp  <= resp_nxt;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_arb.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master_arb
// Self-checking bench: directed vector table, hand-written round-robin and
// reset sequences, and randomized multi-requester traffic checked against a
// queue-based round-robin model. A delay-configurable AXI-Lite slave model
// also checks address/data stability and channel ordering on the bus.
// ---------------------------------------------------------------------------
module tb_axi_lite_master_arb;

    localparam int          NR    = 3;
    localparam logic [3:0]  CACHE = 4'b0011;
    localparam logic [2:0]  PROT  = 3'b010;

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic        b_early;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        int          lat;        // expected req->ack latency in cycles, -1 = unchecked
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    logic              ACLK;
    logic              ARESET;
    logic [NR-1:0]     req, req_we, req_ack;
    logic [NR*32-1:0]  req_addr, req_wdata;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [31:0]       AWADDR, WDATA, ARADDR, RDATA;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [3:0]        AWCACHE, ARCACHE;
    logic [2:0]        AWPROT, ARPROT;
    logic [1:0]        BRESP;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   last_gnt;
    vec_t cur;
    vec_t tbl [8];
    vec_t q   [NR][$];

    axi_lite_master_arb #(
        .NUM_REQ   (NR),
        .AXI_CACHE (CACHE),
        .AXI_PROT  (PROT)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .AWADDR    (AWADDR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWCACHE   (AWCACHE),
        .AWPROT    (AWPROT),
        .WDATA     (WDATA),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .ARADDR    (ARADDR),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARCACHE   (ARCACHE),
        .ARPROT    (ARPROT),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .RREADY    (RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input int idx, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int aw_d, input int w_d,
                                 input int b_d, input int ar_d, input int r_d,
                                 input logic b_early, input logic [1:0] bresp,
                                 input logic [31:0] rdata, input int lat,
                                 input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
        vec_t v;
        v.idx = idx; v.we = we; v.addr = addr; v.wdata = wdata;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
        v.b_early = b_early; v.bresp = bresp; v.rdata = rdata; v.lat = lat;
        v.exp_resp = exp_resp; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    // ---------------- AXI-Lite slave model ----------------
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0, b_arm = 0;

    always @(negedge ACLK) begin
        if (ARESET) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_arm = 0;
        end else begin
            // AW: VALID must be gone the cycle after the handshake
            if (aw_fire) begin
                AWREADY = 0; aw_fire = 0; aw_got = 1; aw_cnt = 0;
                check("awvalid_drop", 32'(AWVALID), 32'd0);
            end else if (AWVALID) begin
                check("awaddr", AWADDR, cur.addr);
                if (aw_cnt >= cur.aw_d) AWREADY = 1; else aw_cnt++;
            end
            if (AWVALID && AWREADY) aw_fire = 1;
            if (AWVALID && cur.b_early) b_arm = 1;

            // W
            if (w_fire) begin
                WREADY = 0; w_fire = 0; w_got = 1; w_cnt = 0;
                check("wvalid_drop", 32'(WVALID), 32'd0);
            end else if (WVALID) begin
                check("wdata", WDATA, cur.wdata);
                if (w_cnt >= cur.w_d) WREADY = 1; else w_cnt++;
            end
            if (WVALID && WREADY) w_fire = 1;

            // B: normally after both AW and W, optionally offered early
            if (b_fire) begin
                BVALID = 0; b_fire = 0; b_arm = 0; b_cnt = 0; aw_got = 0; w_got = 0;
            end else if (!BVALID && (b_arm || (aw_got && w_got))) begin
                if (b_cnt >= cur.b_d) begin BVALID = 1; BRESP = cur.bresp; end
                else b_cnt++;
            end
            if (BVALID && BREADY) b_fire = 1;

            // AR
            if (ar_fire) begin
                ARREADY = 0; ar_fire = 0; ar_got = 1; ar_cnt = 0;
                check("arvalid_drop", 32'(ARVALID), 32'd0);
            end else if (ARVALID) begin
                check("araddr", ARADDR, cur.addr);
                if (ar_cnt >= cur.ar_d) ARREADY = 1; else ar_cnt++;
            end
            if (ARVALID && ARREADY) ar_fire = 1;

            // R
            if (r_fire) begin
                RVALID = 0; r_fire = 0; ar_got = 0; r_cnt = 0;
            end else if (!RVALID && ar_got) begin
                if (r_cnt >= cur.r_d) begin RVALID = 1; RDATA = cur.rdata; end
                else r_cnt++;
            end
            if (RVALID && RREADY) r_fire = 1;

            // Channel ordering rules
            if (BREADY)  check("bready_after_aw_w", 32'(aw_got && w_got), 32'd1);
            if (RREADY)  check("rready_after_ar", 32'(ar_got), 32'd1);
            if (ARVALID) check("ar_excl_aw_w", 32'(AWVALID | WVALID), 32'd0);
        end
    end

    // ---------------- round-robin reference model ----------------
    function automatic int pick();
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (last_gnt + k) % NR;
            if (q[c].size() > 0) return c;
        end
        return -1;
    endfunction

    // Single requester, directed vector with latency and hold checks.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        cur = v;
        req_we[v.idx]            = v.we;
        req_addr[32*v.idx +: 32]  = v.addr;
        req_wdata[32*v.idx +: 32] = v.wdata;
        req[v.idx]               = 1'b1;
        n = 0;
        while (req_ack == '0 && n < 200) begin
            @(negedge ACLK);
            n++;
            // post-grant changes must not reach the bus
            if (n == 1) begin
                req_addr[32*v.idx +: 32]  = ~v.addr;
                req_wdata[32*v.idx +: 32] = v.wdata ^ 32'h5A5A_5A5A;
            end
        end
        check({tag, "_ack"}, 32'(req_ack), 32'(1 << v.idx));
        if (v.lat >= 0) check({tag, "_latency"}, 32'(n), 32'(v.lat));
        check({tag, "_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
        if (!v.we) check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        last_gnt   = v.idx;
        req[v.idx] = 1'b0;
        @(negedge ACLK);
        check({tag, "_ack_pulse"}, 32'(req_ack), 32'd0);
        check({tag, "_resp_held"}, 32'(rsp_resp), 32'(v.exp_resp));
        if (!v.we) check({tag, "_rdata_held"}, rsp_rdata, v.exp_rdata);
    endtask

    // Multiple requesters working through their queues; grant order from model.
    task automatic run_multi(input string tag);
        int   pred, budget;
        logic refresh, was_ack;
        for (int i = 0; i < NR; i++) begin
            req[i] = (q[i].size() > 0);
            if (q[i].size() > 0) begin
                req_we[i] = q[i][0].we;
                req_addr[32*i +: 32]  = q[i][0].addr;
                req_wdata[32*i +: 32] = q[i][0].wdata;
            end
        end
        pred    = pick();
        if (pred >= 0) cur = q[pred][0];
        refresh = 1'b0;
        was_ack = 1'b0;
        budget  = 4000;
        while (pred >= 0 && budget > 0) begin
            @(negedge ACLK);
            budget--;
            if (refresh) begin
                for (int i = 0; i < NR; i++) begin
                    req[i] = (q[i].size() > 0);
                    if (q[i].size() > 0) begin
                        req_we[i] = q[i][0].we;
                        req_addr[32*i +: 32]  = q[i][0].addr;
                        req_wdata[32*i +: 32] = q[i][0].wdata;
                    end
                end
                refresh = 1'b0;
            end
            if (was_ack) check({tag, "_ack_pulse"}, 32'(req_ack), 32'd0);
            was_ack = 1'b0;
            if (req_ack != '0) begin
                check({tag, "_grant"}, 32'(req_ack), 32'(1 << pred));
                check({tag, "_resp"}, 32'(rsp_resp), 32'(q[pred][0].exp_resp));
                if (!q[pred][0].we) check({tag, "_rdata"}, rsp_rdata, q[pred][0].exp_rdata);
                last_gnt  = pred;
                void'(q[pred].pop_front());
                req[pred] = 1'b0;
                refresh   = 1'b1;
                was_ack   = 1'b1;
                pred      = pick();
                if (pred >= 0) cur = q[pred][0];
            end
        end
        n_chk++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: requester %0d still pending", tag, pred);
        end
        req = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
        ARREADY = 0; RVALID = 0; RDATA = '0;
        cur = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, -1, 2'b00, 0);
        last_gnt = NR - 1;

        // idx we addr wdata aw w b ar r early bresp rdata lat exp_resp exp_rdata
        tbl[0] = mkv(0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 2, 2, 0, 0, 0, 0, 2'b00, 32'h0, 5, 2'b00, 32'h0);
        tbl[1] = mkv(1, 0, 32'h0000_2004, 32'h0, 0, 0, 0, 0, 3, 0, 2'b00, 32'hCAFE_F00D, 6, 2'b00, 32'hCAFE_F00D);
        tbl[2] = mkv(0, 1, 32'h0000_3000, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 2'b01, 32'h0, 3, 2'b01, 32'h0);
        tbl[3] = mkv(2, 0, 32'h0000_4008, 32'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h55AA_55AA, 3, 2'b00, 32'h55AA_55AA);
        tbl[4] = mkv(1, 1, 32'h0000_500C, 32'h0BAD_F00D, 3, 0, 0, 0, 0, 1, 2'b00, 32'h0, 6, 2'b00, 32'h0);
        tbl[5] = mkv(0, 1, 32'h0000_6010, 32'h7777_8888, 0, 0, 0, 0, 0, 0, 2'b10, 32'h0, 3, 2'b10, 32'h0);
        tbl[6] = mkv(2, 0, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 2, 1, 0, 2'b00, 32'h1234_5678, 6, 2'b00, 32'h1234_5678);
        tbl[7] = mkv(1, 1, 32'h0000_7000, 32'hA5A5_A5A5, 0, 1, 2, 0, 0, 0, 2'b11, 32'h0, 6, 2'b11, 32'h0);

        // Reset state
        repeat (2) @(negedge ACLK);
        check("rst_valid_ready", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_awaddr", AWADDR, 32'd0);
        check("rst_araddr", ARADDR, 32'd0);
        check("rst_wdata", WDATA, 32'd0);
        check("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
        check("awcache", 32'(AWCACHE), 32'(CACHE));
        check("arcache", 32'(ARCACHE), 32'(CACHE));
        check("awprot", 32'(AWPROT), 32'(PROT));
        check("arprot", 32'(ARPROT), 32'(PROT));
        ARESET = 1'b0;
        @(negedge ACLK);

        // Directed vectors
        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Two requesters held continuously: strict alternation from requester 0
        for (int k = 0; k < 3; k++) begin
            q[0].push_back(mkv(0, 0, 32'h100 + 32'(4*k), 0, 0, 0, 0, 0, 0, 0, 2'b00,
                               32'hA000_0000 + 32'(k), -1, 2'b00, 32'hA000_0000 + 32'(k)));
            q[1].push_back(mkv(1, 1, 32'h200 + 32'(4*k), 32'hB000_0000 + 32'(k), 0, 0, 0, 0, 0, 0,
                               2'b00, 0, -1, 2'b00, 0));
        end
        run_multi("rr");
        @(negedge ACLK);

        // Reset while waiting for B: everything drops at once, no ack follows
        run_vec_stall();

        // Randomized multi-requester traffic
        for (int i = 0; i < NR; i++) begin
            int n;
            n = $urandom_range(4, 7);
            for (int k = 0; k < n; k++) begin
                vec_t v;
                v.idx     = i;
                v.we      = 1'($urandom_range(0, 1));
                v.addr    = $urandom & 32'hFFFF_FFFC;
                v.wdata   = $urandom;
                v.aw_d    = $urandom_range(0, 3);
                v.w_d     = $urandom_range(0, 3);
                v.b_d     = $urandom_range(0, 3);
                v.ar_d    = $urandom_range(0, 3);
                v.r_d     = $urandom_range(0, 3);
                v.b_early = ($urandom_range(0, 3) == 0);
                v.bresp   = 2'($urandom_range(0, 3));
                v.rdata   = $urandom;
                v.lat     = -1;
                v.exp_resp  = v.we ? v.bresp : 2'b00;
                v.exp_rdata = v.rdata;
                q[i].push_back(v);
            end
        end
        run_multi("rand");
        repeat (2) @(negedge ACLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic run_vec_stall();
        int n;
        cur = mkv(0, 1, 32'h0000_9000, 32'h9999_0000, 0, 0, 20, 0, 0, 0, 2'b00, 0, -1, 2'b00, 0);
        req_we[0] = 1'b1;
        req_addr[31:0]  = cur.addr;
        req_wdata[31:0] = cur.wdata;
        req[0] = 1'b1;
        n = 0;
        while (!BREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        check("stall_in_wr_b", 32'(BREADY), 32'd1);
        #1;
        ARESET = 1'b1;
        #1;
        check("arst_valid_ready", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
        check("arst_awaddr", AWADDR, 32'd0);
        check("arst_rsp_resp", 32'(rsp_resp), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            check("arst_no_ack", 32'(req_ack), 32'd0);
        end
        ARESET   = 1'b0;
        last_gnt = NR - 1;
        q[0].push_back(mkv(0, 0, 32'h0000_0A00, 0, 0, 0, 0, 0, 1, 0, 2'b00,
                           32'h0000_AAAA, -1, 2'b00, 32'h0000_AAAA));
        q[1].push_back(mkv(1, 0, 32'h0000_0B00, 0, 0, 0, 0, 1, 0, 0, 2'b00,
                           32'h0000_BBBB, -1, 2'b00, 32'h0000_BBBB));
        run_multi("post_rst");
        @(negedge ACLK);
    endtask

endmodule
